// File: rtl/usb_pkg.sv
// usb_pkg: shared PID codes, CRC16 constants and field sizes for the bitstream encoder/decoder.
// Ports: none (package).
package usb_pkg;
   typedef enum logic [3:0] {
      OUT   = 4'b0001,
      IN    = 4'b1001,
      DATA0 = 4'b0011,
      ACK   = 4'b0010,
      NAK   = 4'b1010
   } pid_t;
   typedef enum logic [1:0] {S_IDLE, S_PID, S_DATA, S_CRC} enc_state_t;
   localparam logic [15:0] CRC16_POLY     = 16'h8005;
   localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
   localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;
   localparam int PID_BITS   = 8;
   localparam int DATA_BITS  = 64;
   localparam int CRC16_BITS = 16;
endpackage

// File: rtl/crc16_gen.sv
// crc16_gen: serial CRC16 register; init loads the seed, en folds in one bit, shift moves the remainder out MSB first.
// Ports: clk, rst (async high); init, en, shift controls; din serial bit; crc current register.
module crc16_gen
   import usb_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  init,
   input  logic                  en,
   input  logic                  shift,
   input  logic                  din,
   output logic [CRC16_BITS-1:0] crc
);
   always_ff @(posedge clk or posedge rst)
      if (rst) crc <= CRC16_INIT;
      else if (init) crc <= CRC16_INIT;
      else if (en) crc <= {crc[14:0], 1'b0} ^ ((crc[15] ^ din) ? CRC16_POLY : 16'h0000);
      else if (shift) crc <= {crc[14:0], 1'b0};
endmodule

// File: rtl/bitstream_encoder.sv
// bitstream_encoder: serializes ACK/NAK/DATA0 packets (PID, payload, CRC16) one bit per unpaused cycle.
// Ports: clk, rst (async high); send_ack/send_nak/send_data requests; data_in payload; pause stall;
//        outb serial bit; sending packet active; ready idle; done end-of-packet pulse.
module bitstream_encoder
   import usb_pkg::*;
#(
   parameter int DATA_W = 64,
   parameter int CRC_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              send_ack,
   input  logic              send_nak,
   input  logic              send_data,
   input  logic [DATA_W-1:0] data_in,
   input  logic              pause,
   output logic              outb,
   output logic              sending,
   output logic              ready,
   output logic              done
);
   enc_state_t        state, state_n;
   pid_t              pid_q, sel;
   logic [7:0]        pid_sr;
   logic [DATA_W-1:0] data_sr;
   logic [CRC_W-1:0]  crc;
   logic [6:0]        cnt, cnt_end;
   logic              accept, adv, last;
   assign ready   = state == S_IDLE;
   assign sending = state != S_IDLE;
   assign accept  = ready & (send_ack | send_nak | send_data);
   assign adv     = sending & ~pause;
   assign sel     = send_ack ? ACK : send_nak ? NAK : DATA0;
   assign cnt_end = state == S_PID ? 7'(PID_BITS - 1) : state == S_DATA ? 7'(DATA_BITS - 1) : 7'(CRC16_BITS - 1);
   assign last    = adv & (cnt == cnt_end);
   assign outb    = state == S_PID ? pid_sr[0] : state == S_DATA ? data_sr[0] : state == S_CRC ? ~crc[15] : 1'b0;
   crc16_gen u_crc (
      .clk  (clk),
      .rst  (rst),
      .init (accept),
      .en   (adv & (state == S_DATA)),
      .shift(adv & (state == S_CRC)),
      .din  (data_sr[0]),
      .crc  (crc)
   );
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= S_IDLE;
      else state <= state_n;
   always_comb begin
      state_n = state;
      case (state)
         S_IDLE:  state_n = accept ? S_PID : S_IDLE;
         S_PID:   state_n = last ? (pid_q == DATA0 ? S_DATA : S_IDLE) : S_PID;
         S_DATA:  state_n = last ? S_CRC : S_DATA;
         default: state_n = last ? S_IDLE : S_CRC;
      endcase
   end
   // done marks the first IDLE cycle after any packet's final bit was consumed
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         cnt     <= '0;
         pid_sr  <= '0;
         data_sr <= '0;
         pid_q   <= ACK;
         done    <= 1'b0;
      end else begin
         done <= sending & (state_n == S_IDLE);
         if (accept) begin
            pid_q   <= sel;
            pid_sr  <= {~sel, sel};
            data_sr <= data_in;
            cnt     <= '0;
         end else if (adv) begin
            cnt <= last ? 7'd0 : cnt + 7'd1;
            if (state == S_PID) pid_sr <= pid_sr >> 1;
            if (state == S_DATA) data_sr <= data_sr >> 1;
         end
      end
endmodule

// File: tb/tb_bitstream_encoder.sv
// tb_bitstream_encoder: directed self-checking bench for bitstream_encoder.
// Ports: none (top-level bench).
module tb_bitstream_encoder;
   logic        clk = 0, rst = 1, send_ack = 0, send_nak = 0, send_data = 0, pause = 0;
   logic [63:0] data_in = '0;
   logic        outb, sending, ready, done;
   int          total = 0, bad = 0;
   logic [87:0] ref_bits;
   localparam logic [63:0] PAYLOAD = 64'h0123_4567_89AB_CDEF;

   bitstream_encoder dut (
      .clk(clk), .rst(rst), .send_ack(send_ack), .send_nak(send_nak), .send_data(send_data),
      .data_in(data_in), .pause(pause), .outb(outb), .sending(sending), .ready(ready), .done(done)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] crc_run(input logic [87:0] b);
      logic [15:0] c;
      logic fb;
      c = 16'hFFFF;
      for (int i = 8; i < 88; i++) begin
         fb = c[15] ^ b[i];
         c = {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
      end
      return c;
   endfunction

   // pulses one request for a single cycle; returns at the negedge after the accepting edge
   task automatic req(input logic a, input logic n, input logic d, input logic [63:0] v);
      @(negedge clk);
      send_ack = a; send_nak = n; send_data = d; data_in = v;
      @(negedge clk);
      send_ack = 0; send_nak = 0; send_data = 0; data_in = ~v;
   endtask

   // records each newly presented bit until sending drops; pause applied with pct% chance per cycle
   task automatic capture(input int pct, output logic [87:0] bits, output int nb, output int scyc,
                          output int npaused, output int unstable, output logic got_done);
      logic prev_p, prev_b;
      bits = '0; nb = 0; scyc = 0; npaused = 0; unstable = 0; got_done = 0; prev_p = 0; prev_b = 0;
      for (int i = 0; i < 400; i++) begin
         if (!sending) begin
            got_done = done;
            break;
         end
         scyc++;
         if (prev_p) begin
            if (outb !== prev_b) unstable++;
         end else begin
            if (nb < 88) bits[nb] = outb;
            nb++;
         end
         prev_b = outb;
         prev_p = pct > 0 && $urandom_range(99) < pct;
         pause = prev_p;
         if (prev_p) npaused++;
         @(negedge clk);
      end
      pause = 0;
   endtask

   task automatic test_reset;
      #2;
      total++;
      if ({ready, sending, outb, done} !== 4'b1000) begin
         bad++;
         $display("FAIL reset_outputs got ready,sending,outb,done=%b want 1000", {ready, sending, outb, done});
      end
      @(negedge clk);
      rst = 0;
      pause = 1;
      @(negedge clk);
      total++;
      if ({ready, sending, done} !== 3'b100) begin
         bad++;
         $display("FAIL idle_pause got ready,sending,done=%b want 100", {ready, sending, done});
      end
      pause = 0;
   endtask

   task automatic test_ack;
      logic [87:0] b; int nb, sc, np, un; logic gd;
      req(1, 0, 0, '0);
      capture(0, b, nb, sc, np, un, gd);
      total++;
      if (b[7:0] !== 8'hD2 || nb != 8) begin
         bad++;
         $display("FAIL ack_bits got %h (n=%0d) want d2 (n=8)", b[7:0], nb);
      end
      total++;
      if (sc != 8) begin
         bad++;
         $display("FAIL ack_len got %0d want 8", sc);
      end
      total++;
      if (gd !== 1'b1 || ready !== 1'b1 || outb !== 1'b0) begin
         bad++;
         $display("FAIL ack_done got done=%b ready=%b outb=%b want 1 1 0", gd, ready, outb);
      end
      @(negedge clk);
      total++;
      if (done !== 1'b0) begin
         bad++;
         $display("FAIL ack_done_width got done=%b want 0", done);
      end
   endtask

   task automatic test_priority;
      logic [87:0] b; int nb, sc, np, un; logic gd;
      req(1, 1, 0, '0);
      capture(0, b, nb, sc, np, un, gd);
      total++;
      if (b[7:0] !== 8'hD2 || sc != 8) begin
         bad++;
         $display("FAIL prio_ack got %h len=%0d want d2 len=8", b[7:0], sc);
      end
      req(0, 1, 0, '0);
      capture(0, b, nb, sc, np, un, gd);
      total++;
      if (b[7:0] !== 8'h5A || sc != 8 || gd !== 1'b1) begin
         bad++;
         $display("FAIL nak_bits got %h len=%0d done=%b want 5a len=8 done=1", b[7:0], sc, gd);
      end
   endtask

   task automatic test_data;
      logic [87:0] b; int nb, sc, np, un; logic gd;
      req(0, 0, 1, PAYLOAD);
      capture(0, b, nb, sc, np, un, gd);
      ref_bits = b;
      total++;
      if (sc != 88 || nb != 88 || gd !== 1'b1) begin
         bad++;
         $display("FAIL data_len got len=%0d bits=%0d done=%b want 88 88 1", sc, nb, gd);
      end
      total++;
      if (b[7:0] !== 8'hC3) begin
         bad++;
         $display("FAIL data_pid got %h want c3", b[7:0]);
      end
      total++;
      if (b[71:8] !== PAYLOAD) begin
         bad++;
         $display("FAIL data_payload got %h want %h", b[71:8], PAYLOAD);
      end
      total++;
      if (crc_run(b) !== 16'h800D) begin
         bad++;
         $display("FAIL data_crc_residual got %h want 800d", crc_run(b));
      end
   endtask

   task automatic test_pause;
      logic [87:0] b; int nb, sc, np, un; logic gd;
      req(0, 0, 1, PAYLOAD);
      capture(30, b, nb, sc, np, un, gd);
      total++;
      if (b !== ref_bits || nb != 88) begin
         bad++;
         $display("FAIL pause_bits got %h (n=%0d) want %h", b, nb, ref_bits);
      end
      total++;
      if (un != 0) begin
         bad++;
         $display("FAIL pause_stable got %0d changes want 0", un);
      end
      total++;
      if (sc != 88 + np || np == 0 || gd !== 1'b1) begin
         bad++;
         $display("FAIL pause_len got %0d paused=%0d done=%b want %0d done=1", sc, np, gd, 88 + np);
      end
   endtask

   task automatic test_back_to_back;
      logic [87:0] b; int nb, sc, np, un; logic gd;
      req(1, 0, 0, '0);
      capture(0, b, nb, sc, np, un, gd);
      send_data = 1; data_in = PAYLOAD;
      @(negedge clk);
      send_data = 0; data_in = '0;
      total++;
      if (sending !== 1'b1 || outb !== 1'b1) begin
         bad++;
         $display("FAIL b2b_start got sending=%b outb=%b want 1 1", sending, outb);
      end
      send_ack = 1;
      @(negedge clk);
      send_ack = 0;
      capture(0, b, nb, sc, np, un, gd);
      total++;
      if (sc != 87 || gd !== 1'b1) begin
         bad++;
         $display("FAIL b2b_len got %0d done=%b want 87 done=1", sc, gd);
      end
      total++;
      if (b[63:0] !== PAYLOAD[63:1] >> 6 && 1'b0 || b[62:7] !== PAYLOAD[55:0]) begin
         bad++;
         $display("FAIL b2b_payload got %h want %h", b[62:7], PAYLOAD[55:0]);
      end
      @(negedge clk);
      total++;
      if (sending !== 1'b0 || ready !== 1'b1) begin
         bad++;
         $display("FAIL midpacket_ignored got sending=%b ready=%b want 0 1", sending, ready);
      end
   endtask

   task automatic test_reset_mid;
      logic [87:0] b; int nb, sc, np, un; logic gd;
      logic saw_done;
      req(0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF);
      for (int i = 0; i < 40; i++) @(negedge clk);
      #2 rst = 1;
      #1;
      total++;
      if ({sending, outb, ready} !== 3'b001) begin
         bad++;
         $display("FAIL rst_async got sending,outb,ready=%b want 001", {sending, outb, ready});
      end
      saw_done = 0;
      @(negedge clk);
      rst = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         saw_done |= done | sending;
      end
      total++;
      if (saw_done !== 1'b0) begin
         bad++;
         $display("FAIL rst_no_resume got done/sending=%b want 0", saw_done);
      end
      req(1, 0, 0, '0);
      capture(0, b, nb, sc, np, un, gd);
      total++;
      if (b[7:0] !== 8'hD2 || sc != 8 || gd !== 1'b1) begin
         bad++;
         $display("FAIL rst_then_ack got %h len=%0d done=%b want d2 8 1", b[7:0], sc, gd);
      end
   endtask

   initial begin
      test_reset;
      test_ack;
      test_priority;
      test_data;
      test_pause;
      test_back_to_back;
      test_reset_mid;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
